// File: rtl/bram0_loader.sv
// Byte-stream loader for BRAM0: packs four stream lanes per word, writes words from address 0,
// then hands the clamped word count to the accessor with a one-cycle start pulse.
module bram0_loader #(
   parameter int CNT_BIT       = 31,
   parameter int DWIDTH_1      = 32,
   parameter int AWIDTH        = 8,
   parameter int MEM_SIZE      = 256,
   parameter int IN_DATA_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_load_i,
   input  logic [CNT_BIT-1:0]       word_count_i,
   input  logic                     s_valid_i,
   input  logic [IN_DATA_WIDTH-1:0] s_data_i,
   output logic                     s_ready_o,
   output logic [AWIDTH-1:0]        addr_b0_o,
   output logic                     ce_b0_o,
   output logic                     we_b0_o,
   output logic [DWIDTH_1-1:0]      d_b0_o,
   output logic                     idle_o,
   output logic                     load_o,
   output logic                     done_o,
   output logic                     start_run_o,
   output logic [CNT_BIT-1:0]       run_count_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]                        state;
   logic [CNT_BIT-1:0]                target;
   logic [1:0]                        byte_idx;
   logic [AWIDTH-1:0]                 word_idx;
   logic [DWIDTH_1-IN_DATA_WIDTH-1:0] pack;
   logic [CNT_BIT-1:0]                clamped;
   logic                              accept;
   logic                              last_word;

   assign s_ready_o = (state == LOAD);
   assign idle_o    = (state == IDLE);
   assign load_o    = (state == LOAD) || (state == FLUSH);
   assign accept    = s_valid_i & s_ready_o;
   assign last_word = (CNT_BIT'(word_idx) == (target - CNT_BIT'(1)));

   // Clamping to the memory depth keeps the word index from ever wrapping.
   assign clamped = (word_count_i > CNT_BIT'(MEM_SIZE)) ? CNT_BIT'(MEM_SIZE) : word_count_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         target      <= '0;
         byte_idx    <= '0;
         word_idx    <= '0;
         pack        <= '0;
         addr_b0_o   <= '0;
         d_b0_o      <= '0;
         ce_b0_o     <= 1'b0;
         we_b0_o     <= 1'b0;
         done_o      <= 1'b0;
         start_run_o <= 1'b0;
         run_count_o <= '0;
      end else begin
         ce_b0_o     <= 1'b0;
         we_b0_o     <= 1'b0;
         done_o      <= 1'b0;
         start_run_o <= 1'b0;
         run_count_o <= '0;
         case (state)
            IDLE: begin
               if (start_load_i) begin
                  target   <= clamped;
                  byte_idx <= '0;
                  word_idx <= '0;
                  if (clamped == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  // The fourth lane completes the word; the write lands while the next word packs.
                  if (byte_idx == 2'd3) begin
                     ce_b0_o   <= 1'b1;
                     we_b0_o   <= 1'b1;
                     addr_b0_o <= word_idx;
                     d_b0_o    <= {pack, s_data_i};
                     byte_idx  <= '0;
                     if (last_word) begin
                        state <= FLUSH;
                     end else begin
                        word_idx <= word_idx + AWIDTH'(1);
                     end
                  end else begin
                     pack     <= {pack[DWIDTH_1-2*IN_DATA_WIDTH-1:0], s_data_i};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            FLUSH: begin
               state       <= DONE;
               done_o      <= 1'b1;
               start_run_o <= 1'b1;
               run_count_o <= target;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
